// File: rtl/mor1kx_multicycle_divider.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mor1kx_multicycle_divider : radix-2 restoring divider for l.div / l.divu
// Revision 1.0
// ---------------------------------------------------------------------------
module mor1kx_multicycle_divider #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int OP_MAX_CLOCKS        = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            decode_valid_i,
  input  logic                            pipeline_flush_i,
  input  logic                            op_div_i,
  input  logic                            op_div_signed_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] a_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] b_i,
  output logic                            div_busy_o,
  output logic                            div_valid_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] result_o,
  output logic                            overflow_o
);

  localparam int W  = OPTION_OPERAND_WIDTH;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [W-1:0] ONE     = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  generate
    if (OPTION_OPERAND_WIDTH + 1 > OP_MAX_CLOCKS + 1) begin : g_latency_check
      $error("divider latency exceeds OP_MAX_CLOCKS");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [W-1:0]  divisor;
  logic [W-1:0]  rem;
  logic [W-1:0]  quot;
  logic [CW-1:0] count;
  logic          neg;
  logic          div_zero;
  logic          signed_ovf;

  logic          start;
  logic          a_neg;
  logic          b_neg;
  logic [W-1:0]  a_mag;
  logic [W-1:0]  b_mag;
  logic [W:0]    rem_sh;
  logic [W:0]    diff;
  logic [W-1:0]  quot_next;
  logic [W-1:0]  rem_next;
  logic [W-1:0]  quot_final;

  always_comb begin
    start      = decode_valid_i & op_div_i & ~pipeline_flush_i;
    a_neg      = op_div_signed_i & a_i[W-1];
    b_neg      = op_div_signed_i & b_i[W-1];
    a_mag      = a_neg ? (~a_i + ONE) : a_i;
    b_mag      = b_neg ? (~b_i + ONE) : b_i;
    // Remainder stays below the divisor, so W+1 bits hold the shifted value.
    rem_sh     = {rem, quot[W-1]};
    diff       = rem_sh - {1'b0, divisor};
    quot_next  = {quot[W-2:0], ~diff[W]};
    rem_next   = diff[W] ? rem_sh[W-1:0] : diff[W-1:0];
    quot_final = neg ? (~quot_next + ONE) : quot_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      divisor     <= '0;
      rem         <= '0;
      quot        <= '0;
      count       <= '0;
      neg         <= 1'b0;
      div_zero    <= 1'b0;
      signed_ovf  <= 1'b0;
      div_busy_o  <= 1'b0;
      div_valid_o <= 1'b0;
      result_o    <= '0;
      overflow_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          div_valid_o <= 1'b0;
          if (start) begin
            quot       <= a_mag;
            divisor    <= b_mag;
            rem        <= '0;
            count      <= CW'(W - 1);
            neg        <= a_neg ^ b_neg;
            div_zero   <= (b_i == '0);
            signed_ovf <= op_div_signed_i & (a_i == MIN_NEG) & (b_i == '1);
            div_busy_o <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          if (pipeline_flush_i) begin
            div_busy_o <= 1'b0;
            state      <= IDLE;
          end else begin
            rem   <= rem_next;
            quot  <= quot_next;
            count <= count - CW'(1);
            if (count == '0) begin
              result_o    <= div_zero ? '1 : (signed_ovf ? MIN_NEG : quot_final);
              overflow_o  <= div_zero | signed_ovf;
              div_valid_o <= 1'b1;
              div_busy_o  <= 1'b0;
              state       <= DONE;
            end
          end
        end
        DONE: begin
          div_valid_o <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          div_valid_o <= 1'b0;
          div_busy_o  <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mor1kx_multicycle_divider.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mor1kx_multicycle_divider : directed vectors for the multicycle divider
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_mor1kx_multicycle_divider;

  logic        clk;
  logic        rst;
  logic        decode_valid;
  logic        flush;
  logic        op_div;
  logic        op_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        valid;
  logic [31:0] result;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  mor1kx_multicycle_divider #(
    .OPTION_OPERAND_WIDTH(32),
    .OP_MAX_CLOCKS       (32)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .decode_valid_i  (decode_valid),
    .pipeline_flush_i(flush),
    .op_div_i        (op_div),
    .op_div_signed_i (op_signed),
    .a_i             (a),
    .b_i             (b),
    .div_busy_o      (busy),
    .div_valid_o     (valid),
    .result_o        (result),
    .overflow_o      (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one divide for a single cycle; returns just after the sampling edge.
  task automatic start_op(input logic sg, input logic [31:0] av, input logic [31:0] bv);
    decode_valid = 1'b1;
    op_div       = 1'b1;
    op_signed    = sg;
    a            = av;
    b            = bv;
    step();
    decode_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n, output int bc);
    logic got;
    n   = 0;
    bc  = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      step();
      n++;
      if (busy) bc++;
      if (valid) got = 1'b1;
    end
  endtask

  task automatic run_div(input string tag, input logic sg, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] er, input logic eo);
    int n;
    int bc;
    int bc0;
    start_op(sg, av, bv);
    bc0 = busy ? 1 : 0;
    wait_valid(n, bc);
    check({tag, "_latency"}, 32'(n + 1), 32'd33);
    check({tag, "_busy_cycles"}, 32'(bc + bc0), 32'd32);
    check({tag, "_result"}, result, er);
    check({tag, "_overflow"}, {31'd0, overflow}, {31'd0, eo});
    step();
    check({tag, "_pulse_width"}, {31'd0, valid}, 32'd0);
  endtask

  initial begin
    int n;
    int bc;
    int pulses;
    rst          = 1'b1;
    decode_valid = 1'b0;
    flush        = 1'b0;
    op_div       = 1'b0;
    op_signed    = 1'b0;
    a            = '0;
    b            = '0;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_overflow", {31'd0, overflow}, 32'd0);

    // Non-divide op and flushed start must not launch the unit.
    decode_valid = 1'b1; op_div = 1'b0; a = 32'd9; b = 32'd3;
    step();
    check("non_div_ignored", {31'd0, busy}, 32'd0);
    op_div = 1'b1; flush = 1'b1;
    step();
    check("flushed_start_ignored", {31'd0, busy}, 32'd0);
    decode_valid = 1'b0; flush = 1'b0;

    run_div("u100_7",    1'b0, 32'd100,      32'd7,          32'd14,         1'b0);
    run_div("s-100_7",   1'b1, 32'hFFFFFF9C, 32'd7,          32'hFFFFFFF2,   1'b0);
    run_div("s100_-7",   1'b1, 32'd100,      32'hFFFFFFF9,   32'hFFFFFFF2,   1'b0);
    run_div("s-100_-7",  1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9,   32'd14,         1'b0);
    run_div("u_dbz",     1'b0, 32'h12345678, 32'd0,          32'hFFFFFFFF,   1'b1);
    run_div("s_dbz",     1'b1, 32'h12345678, 32'd0,          32'hFFFFFFFF,   1'b1);
    run_div("s_minneg",  1'b1, 32'h80000000, 32'hFFFFFFFF,   32'h80000000,   1'b1);
    run_div("u_max_1",   1'b0, 32'hFFFFFFFF, 32'd1,          32'hFFFFFFFF,   1'b0);
    run_div("u_small",   1'b0, 32'd7,        32'd100,        32'd0,          1'b0);
    run_div("s_minneg2", 1'b1, 32'h80000000, 32'd2,          32'hC0000000,   1'b0);

    // Back-to-back: second request in DONE is ignored, accepted one cycle later.
    start_op(1'b0, 32'd1000, 32'd10);
    wait_valid(n, bc);
    check("b2b_first_result", result, 32'd100);
    decode_valid = 1'b1; op_signed = 1'b0; a = 32'd999; b = 32'd3;
    step();
    check("b2b_ignored_in_done", {31'd0, busy}, 32'd0);
    step();
    decode_valid = 1'b0;
    check("b2b_accepted", {31'd0, busy}, 32'd1);
    check("b2b_held_at_accept", result, 32'd100);
    repeat (16) step();
    check("b2b_held_mid_run", result, 32'd100);
    wait_valid(n, bc);
    check("b2b_latency", 32'(n + 17), 32'd33);
    check("b2b_second_result", result, 32'd333);
    step();

    // Flush at RUN step 10.
    start_op(1'b0, 32'd100, 32'd7);
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_idle", {31'd0, busy}, 32'd0);
    check("flush_valid_low", {31'd0, valid}, 32'd0);
    pulses = 0;
    repeat (40) begin
      step();
      if (valid) pulses++;
    end
    check("flush_no_pulse", 32'(pulses), 32'd0);
    check("flush_result_held", result, 32'd333);

    // Flush coincident with the final step.
    start_op(1'b0, 32'd50, 32'd5);
    repeat (31) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_last_no_valid", {31'd0, valid}, 32'd0);
    check("flush_last_idle", {31'd0, busy}, 32'd0);
    check("flush_last_result_held", result, 32'd333);

    // Reset mid-RUN after an overflowing result.
    run_div("pre_rst_dbz", 1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b1);
    start_op(1'b1, 32'hFFFFFF9C, 32'd7);
    repeat (5) step();
    rst = 1'b1;
    step();
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_valid", {31'd0, valid}, 32'd0);
    check("rst_mid_result", result, 32'd0);
    check("rst_mid_overflow", {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    pulses = 0;
    repeat (40) begin
      step();
      if (valid) pulses++;
    end
    check("rst_mid_no_pulse", 32'(pulses), 32'd0);

    run_div("post_rst", 1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
